// File: rtl/slsr_pkg.sv
// Shared types and constants for the left/right shift-register loader.
// Holds the default word width, the loader FSM state encoding and the
// shift-direction encoding sampled alongside each accepted word.
package slsr_pkg;

  localparam int SLSR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } slsr_ld_state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } slsr_dir_e;

endpackage

// File: rtl/slsr_loader.sv
// Serialises a parallel word into sl/sr/din strobes for a left/right shift register.
// Latency: bit k strobed in cycle k after accept, done pulse WIDTH cycles after accept.
// Backpressure: in_ready only in IDLE; hold stalls a SHIFT cycle and inserts one idle cycle.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_data/in_dir : word handshake, in_dir 0 = MSB first via sl
//   hold                             : stall while shifting
//   sl/sr/din                        : registered strobes and serial bit to downstream
//   busy/done                        : word in flight / one-cycle completion pulse
module slsr_loader
  import slsr_pkg::*;
#(
  parameter int WIDTH = SLSR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic             hold,
  output logic             sl,
  output logic             sr,
  output logic             din,
  output logic             busy,
  output logic             done
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  slsr_ld_state_e   state_q, state_d;
  slsr_dir_e        dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    idx_nxt;
  logic             sl_q, sl_d;
  logic             sr_q, sr_d;
  logic             din_q, din_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             strobe;

  // A strobe visible in the current cycle is captured downstream at the
  // coming edge, so idx_q only advances past a bit once it has been strobed.
  assign strobe  = sl_q | sr_q;
  assign idx_nxt = strobe ? idx_q + IW'(1) : idx_q;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    data_d  = data_q;
    idx_d   = idx_q;
    sl_d    = 1'b0;
    sr_d    = 1'b0;
    din_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && rdy_q) begin
          state_d = SHIFT;
          data_d  = in_data;
          dir_d   = slsr_dir_e'(in_dir);
          idx_d   = '0;
          // Bit 0 goes out in the cycle right after the accepting edge.
          sl_d    = ~in_dir;
          sr_d    = in_dir;
          din_d   = in_dir ? in_data[0] : in_data[WIDTH-1];
        end
      end
      SHIFT: begin
        if (strobe && (idx_q == LAST)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_nxt;
          if (!hold) begin
            sl_d  = (dir_q == DIR_LEFT);
            sr_d  = (dir_q == DIR_RIGHT);
            din_d = (dir_q == DIR_RIGHT) ? data_q[idx_nxt] : data_q[LAST - idx_nxt];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dir_q   <= DIR_LEFT;
      data_q  <= '0;
      idx_q   <= '0;
      sl_q    <= 1'b0;
      sr_q    <= 1'b0;
      din_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      din_q   <= din_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = rdy_q;
  assign sl       = sl_q;
  assign sr       = sr_q;
  assign din      = din_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_slsr_loader.sv
// Bench for slsr_loader driving an 8-bit left/right shift register; Q checked end-to-end.
module tb_slsr_loader;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_dir;
  logic       hold;
  logic       sl;
  logic       sr;
  logic       din;
  logic       busy;
  logic       done;
  logic [7:0] q;

  int checks = 0;
  int errors = 0;

  slsr_loader #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dir   (in_dir),
    .hold     (hold),
    .sl       (sl),
    .sr       (sr),
    .din      (din),
    .busy     (busy),
    .done     (done)
  );

  // Downstream left/right shift register stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= 8'h00;
    else if (sl) q <= {q[6:0], din};
    else if (sr) q <= {din, q[7:1]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one word and watch it through to the cycle after done.
  // hv[c] is the hold value driven into edge E_c (E_0 = accepting edge).
  // Cycle c is the cycle following edge E_{c-1}.
  task automatic word(input logic [7:0] data, input logic dir, input logic [15:0] hv,
                      input logic [7:0] exp_seq, input int exp_done, input string tag);
    int         nsl;
    int         nsr;
    int         ndone;
    int         done_at;
    logic [7:0] seq;
    logic       both;
    nsl = 0; nsr = 0; ndone = 0; done_at = 0; seq = 8'h00; both = 1'b0;
    chk({tag, ".ready_before"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_dir   = dir;
    hold     = hv[0];
    tick();
    in_valid = 1'b0;
    in_data  = ~data;
    in_dir   = ~dir;
    hold     = 1'b0;
    chk({tag, ".busy_ready_after_accept"}, 32'({busy, in_ready}), 32'b10);
    for (int c = 1; c <= exp_done + 1; c++) begin
      if (sl) nsl++;
      if (sr) nsr++;
      if (sl | sr) seq = {seq[6:0], din};
      if (sl & sr) both = 1'b1;
      if (done) begin
        ndone++;
        if (done_at == 0) done_at = c;
      end
      if (c == exp_done) chk({tag, ".busy_in_done"}, 32'(busy), 32'd1);
      if (c == exp_done + 1) chk({tag, ".ready_busy_end"}, 32'({in_ready, busy}), 32'b10);
      hold = (c <= 15) ? hv[c] : 1'b0;
      if (c <= exp_done) tick();
    end
    hold = 1'b0;
    chk({tag, ".sl_count"}, 32'(nsl), dir ? 32'd0 : 32'd8);
    chk({tag, ".sr_count"}, 32'(nsr), dir ? 32'd8 : 32'd0);
    chk({tag, ".din_seq"}, 32'(seq), 32'(exp_seq));
    chk({tag, ".done_cycle"}, 32'(done_at), 32'(exp_done));
    chk({tag, ".done_pulses"}, 32'(ndone), 32'd1);
    chk({tag, ".sl_sr_exclusive"}, 32'(both), 32'd0);
    chk({tag, ".q"}, 32'(q), 32'(data));
  endtask

  initial begin
    int         ndone;
    int         first_strobe;
    int         nstrobe;
    logic [7:0] q_mid;

    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_dir   = 1'b0;
    hold     = 1'b0;

    // 1. reset behaviour
    #1;
    chk("reset.outputs_early", 32'({in_ready, sl, sr, din, busy, done}), 32'd0);
    tick(); tick(); tick();
    chk("reset.outputs_held", 32'({in_ready, sl, sr, din, busy, done}), 32'd0);
    chk("reset.q", 32'(q), 32'h00);
    reset = 1'b1;
    #1;
    chk("reset.ready_before_edge", 32'(in_ready), 32'd0);
    tick();
    chk("reset.ready_after_edge", 32'(in_ready), 32'd1);
    chk("reset.idle_outputs", 32'({sl, sr, din, busy, done}), 32'd0);

    // 2. left load 0xA5
    word(8'hA5, 1'b0, 16'h0000, 8'hA5, 9, "left_a5");
    // 3. right load 0x3C, hold asserted on the accept edge and in DONE (no effect)
    word(8'h3C, 1'b1, 16'h0201, 8'h3C, 9, "right_3c");
    // asymmetric right load: LSB first 1,1,0,1,0,0,0,0
    word(8'h0B, 1'b1, 16'h0000, 8'hD0, 9, "right_0b");
    // 4. stall: hold into edges E2,E3 (bit 2) and E7,E8 (bit 5)
    word(8'hF0, 1'b0, 16'h018C, 8'hF0, 13, "stall_f0");

    // 5. reset mid-word
    in_valid = 1'b1; in_data = 8'hFF; in_dir = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("midreset.strobing", 32'({sl, busy}), 32'b11);
    reset = 1'b0;
    #1;
    chk("midreset.outputs_drop", 32'({in_ready, sl, sr, din, busy, done}), 32'd0);
    ndone = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done) ndone++;
    end
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done) ndone++;
    end
    chk("midreset.no_done", 32'(ndone), 32'd0);
    chk("midreset.ready", 32'(in_ready), 32'd1);
    word(8'h81, 1'b0, 16'h0000, 8'h81, 9, "after_reset_81");

    // 6. back-to-back with in_valid held high
    in_valid = 1'b1; in_data = 8'h12; in_dir = 1'b0;
    tick();
    ndone = 0; first_strobe = 0; nstrobe = 0; q_mid = 8'h00;
    for (int c = 1; c <= 20; c++) begin
      if (sl | sr) nstrobe++;
      if (c > 9 && (sl | sr) && first_strobe == 0) first_strobe = c;
      if (done) ndone++;
      if (c == 10) q_mid = q;
      if (c == 2) begin in_data = 8'hFF; in_dir = 1'b1; end
      if (c == 10) begin in_data = 8'h34; in_dir = 1'b0; end
      if (c == 11) in_valid = 1'b0;
      if (c < 20) tick();
    end
    chk("b2b.first_word_q", 32'(q_mid), 32'h12);
    chk("b2b.second_start", 32'(first_strobe), 32'd11);
    chk("b2b.strobes", 32'(nstrobe), 32'd16);
    chk("b2b.done_pulses", 32'(ndone), 32'd2);
    chk("b2b.final_q", 32'(q), 32'h34);
    chk("b2b.idle", 32'({in_ready, busy}), 32'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
